// File: rtl/lives_rect_controller.sv
// lives_rect_controller
//   Coordinate front end for the lives (hearts) bitmap plus the player lives
//   state machine.  The raster position is converted into a registered
//   draw-enable and bitmap-relative offsets; lost hearts and the blink phase
//   of the invulnerability window are hidden by masking the draw-enable.
//
// Ports
//   clk             system clock
//   resetN          synchronous reset, active-high despite the name
//   startOfFrame    one-cycle pulse per video frame
//   pixelX/pixelY   current raster position (11 bits each)
//   hit             one-cycle pulse: player was hit
//   addLife         one-cycle pulse: bonus life
//   offsetX/offsetY registered position relative to the row's top-left corner
//                   (0 when outside the row)
//   InsideRectangle registered, masked draw-enable for the bitmap
//   lives           remaining lives, 0..MAX_LIVES
//   invulnerable    high while in the invulnerability window
//   gameOver        high once lives reach zero, until reset
module lives_rect_controller #(
  parameter int unsigned TOP_LEFT_X    = 16,
  parameter int unsigned TOP_LEFT_Y    = 8,
  parameter int unsigned HEART_W       = 20,
  parameter int unsigned HEART_H       = 16,
  parameter int unsigned MAX_LIVES     = 3,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_PERIOD  = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        hit,
  input  logic        addLife,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [1:0]  lives,
  output logic        invulnerable,
  output logic        gameOver
);

  localparam int unsigned INV_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam int unsigned BLK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  localparam logic [10:0]      X_LO       = 11'(TOP_LEFT_X);
  localparam logic [10:0]      X_HI       = 11'(TOP_LEFT_X + HEART_W * MAX_LIVES - 1);
  localparam logic [10:0]      Y_LO       = 11'(TOP_LEFT_Y);
  localparam logic [10:0]      Y_HI       = 11'(TOP_LEFT_Y + HEART_H - 1);
  localparam logic [10:0]      HEART_W_11 = 11'(HEART_W);
  localparam logic [1:0]       MAX_L      = 2'(MAX_LIVES);
  localparam logic [INV_W-1:0] INV_LOAD   = INV_W'(INVULN_FRAMES);
  localparam logic [INV_W-1:0] INV_ONE    = INV_W'(1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_ALIVE,
    ST_INVULN,
    ST_DEAD
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [INV_W-1:0] invuln_cnt_q, invuln_cnt_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_hide_q, blink_hide_d;
  logic             invulnerable_q, invulnerable_d;
  logic             game_over_q, game_over_d;

  logic [10:0]      offset_x_q, offset_x_d;
  logic [10:0]      offset_y_q, offset_y_d;
  logic             inside_q, inside_d;

  // Geometry and mask
  logic        in_x, in_y, in_rect;
  logic [10:0] rel_x, rel_y;
  logic [10:0] live_span;
  logic        can_add;

  always_comb begin
    in_x    = (pixelX >= X_LO) && (pixelX <= X_HI);
    in_y    = (pixelY >= Y_LO) && (pixelY <= Y_HI);
    in_rect = in_x && in_y;
    rel_x   = pixelX - X_LO;
    rel_y   = pixelY - Y_LO;
    // Span covered by remaining hearts; constant multiply keeps this divider-free.
    live_span  = 11'(lives_q) * HEART_W_11;
    // Offsets only propagate while inside the row, so the wrapped
    // subtraction results outside it never reach the outputs.
    offset_x_d = in_rect ? rel_x : '0;
    offset_y_d = in_rect ? rel_y : '0;
    inside_d   = in_rect && (rel_x < live_span) && !blink_hide_q;
  end

  // Lives / invulnerability state machine
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    invuln_cnt_d = invuln_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    blink_hide_d = blink_hide_q;
    can_add      = addLife && (lives_q < MAX_L);

    unique case (state_q)
      ST_ALIVE: begin
        // hit takes priority; a simultaneous addLife is dropped.
        if (hit) begin
          if (lives_q > 2'd1) begin
            lives_d      = lives_q - 2'd1;
            state_d      = ST_INVULN;
            invuln_cnt_d = INV_LOAD;
            blink_cnt_d  = '0;
            blink_hide_d = 1'b1;
          end else begin
            lives_d = '0;
            state_d = ST_DEAD;
          end
        end else if (can_add) begin
          lives_d = lives_q + 2'd1;
        end
      end

      ST_INVULN: begin
        // hit is ignored here; addLife is independent of the frame counters.
        if (can_add) begin
          lives_d = lives_q + 2'd1;
        end
        if (startOfFrame) begin
          if (invuln_cnt_q <= INV_ONE) begin
            state_d      = ST_ALIVE;
            invuln_cnt_d = '0;
            blink_cnt_d  = '0;
            blink_hide_d = 1'b0;
          end else begin
            invuln_cnt_d = invuln_cnt_q - INV_ONE;
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d  = '0;
              blink_hide_d = ~blink_hide_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
          end
        end
      end

      ST_DEAD: begin
        // Terminal until reset.
      end

      default: begin
        state_d = ST_ALIVE;
      end
    endcase

    // Status flags are registered from the next state so they change on the
    // same edge as the state itself.
    invulnerable_d = (state_d == ST_INVULN);
    game_over_d    = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q        <= ST_ALIVE;
      lives_q        <= MAX_L;
      invuln_cnt_q   <= '0;
      blink_cnt_q    <= '0;
      blink_hide_q   <= 1'b0;
      invulnerable_q <= 1'b0;
      game_over_q    <= 1'b0;
      offset_x_q     <= '0;
      offset_y_q     <= '0;
      inside_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      invuln_cnt_q   <= invuln_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_hide_q   <= blink_hide_d;
      invulnerable_q <= invulnerable_d;
      game_over_q    <= game_over_d;
      offset_x_q     <= offset_x_d;
      offset_y_q     <= offset_y_d;
      inside_q       <= inside_d;
    end
  end

  assign offsetX         = offset_x_q;
  assign offsetY         = offset_y_q;
  assign InsideRectangle = inside_q;
  assign lives           = lives_q;
  assign invulnerable    = invulnerable_q;
  assign gameOver        = game_over_q;

endmodule

// File: tb/tb_lives_rect_controller.sv
// Directed self-checking bench for lives_rect_controller (default parameters).
module tb_lives_rect_controller;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        hit;
  logic        addLife;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic [1:0]  lives;
  logic        invulnerable;
  logic        gameOver;

  int unsigned n_checks;
  int unsigned n_fails;

  lives_rect_controller #(
    .TOP_LEFT_X   (16),
    .TOP_LEFT_Y   (8),
    .HEART_W      (20),
    .HEART_H      (16),
    .MAX_LIVES    (3),
    .INVULN_FRAMES(120),
    .BLINK_PERIOD (8)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .hit            (hit),
    .addLife        (addLife),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle),
    .lives          (lives),
    .invulnerable   (invulnerable),
    .gameOver       (gameOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pixel for one cycle and check the registered result.
  task automatic pix(input string tag, input int unsigned x, input int unsigned y,
                     input logic exp_in, input int unsigned exp_ox, input int unsigned exp_oy);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
    check({tag, ".inside"}, 32'(InsideRectangle), 32'(exp_in));
    check({tag, ".offx"}, 32'(offsetX), 32'(exp_ox));
    check({tag, ".offy"}, 32'(offsetY), 32'(exp_oy));
  endtask

  task automatic pulse(input logic do_hit, input logic do_add, input logic do_sof);
    hit          = do_hit;
    addLife      = do_add;
    startOfFrame = do_sof;
    tick();
    hit          = 1'b0;
    addLife      = 1'b0;
    startOfFrame = 1'b0;
  endtask

  // One frame pulse followed by an idle cycle so the draw-enable reflects the
  // post-pulse blink phase.
  task automatic frame();
    pulse(1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic status(input string tag, input int unsigned exp_l,
                        input logic exp_inv, input logic exp_go);
    check({tag, ".lives"}, 32'(lives), 32'(exp_l));
    check({tag, ".invuln"}, 32'(invulnerable), 32'(exp_inv));
    check({tag, ".gameover"}, 32'(gameOver), 32'(exp_go));
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    resetN       = 1'b1;
    startOfFrame = 1'b0;
    hit          = 1'b0;
    addLife      = 1'b0;
    pixelX       = 11'd16;
    pixelY       = 11'd8;

    // Reset state (pixel inside the row must still read as 0)
    tick();
    tick();
    status("rst", 3, 1'b0, 1'b0);
    check("rst.inside", 32'(InsideRectangle), 32'd0);
    check("rst.offx", 32'(offsetX), 32'd0);
    check("rst.offy", 32'(offsetY), 32'd0);
    resetN = 1'b0;

    // Geometry boundaries, full lives
    pix("tl", 16, 8, 1'b1, 0, 0);
    pix("br", 75, 23, 1'b1, 59, 15);
    pix("xhi", 76, 8, 1'b0, 0, 0);
    pix("xlo", 15, 8, 1'b0, 0, 0);
    pix("yhi", 16, 24, 1'b0, 0, 0);
    pix("ylo", 16, 7, 1'b0, 0, 0);
    pix("mid3", 60, 12, 1'b1, 44, 4);

    // addLife saturates at MAX_LIVES
    pulse(1'b0, 1'b1, 1'b0);
    status("addsat", 3, 1'b0, 1'b0);

    // First hit: 3 -> 2, enter invulnerability with hearts hidden
    pulse(1'b1, 1'b0, 1'b0);
    status("hit1", 2, 1'b1, 1'b0);
    pix("hit1.blink", 20, 10, 1'b0, 4, 2);
    pix("hit1.lost", 56, 10, 1'b0, 40, 2);
    pix("hit1.edge", 55, 10, 1'b0, 39, 2);

    // Walk the invulnerability window; blink toggles every 8 frame pulses
    pixelX = 11'd20;
    pixelY = 11'd10;
    for (int unsigned k = 1; k <= 120; k++) begin
      frame();
      if (k == 1 || k == 7 || k == 8 || k == 15 || k == 16 || k == 119)
        check($sformatf("blink.k%0d", k), 32'(InsideRectangle), ((k / 8) % 2 == 1) ? 32'd1 : 32'd0);
      if (k == 50) begin
        pulse(1'b1, 1'b0, 1'b0);
        status("invhit", 2, 1'b1, 1'b0);
      end
      if (k == 119)
        status("k119", 2, 1'b1, 1'b0);
    end
    status("k120", 2, 1'b0, 1'b0);
    pix("alive2.lost", 56, 10, 1'b0, 40, 2);
    pix("alive2.vis", 55, 10, 1'b1, 39, 2);
    pix("alive2.first", 20, 10, 1'b1, 4, 2);

    // Second hit: 2 -> 1
    pulse(1'b1, 1'b0, 1'b0);
    status("hit2", 1, 1'b1, 1'b0);
    for (int unsigned k = 1; k <= 120; k++) frame();
    status("exp2", 1, 1'b0, 1'b0);
    pix("alive1.lost", 36, 10, 1'b0, 20, 2);
    pix("alive1.vis", 35, 10, 1'b1, 19, 2);

    // Third hit: 1 -> 0, game over; everything is ignored afterwards
    pulse(1'b1, 1'b0, 1'b0);
    status("hit3", 0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    status("dead.hit", 0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    status("dead.add", 0, 1'b0, 1'b1);
    pulse(1'b1, 1'b1, 1'b1);
    status("dead.all", 0, 1'b0, 1'b1);
    pix("dead.pix", 16, 8, 1'b0, 0, 0);

    // Reset leaves game over
    resetN = 1'b1;
    pulse(1'b1, 1'b1, 1'b1);
    status("rst2", 3, 1'b0, 1'b0);
    resetN = 1'b0;

    // hit+addLife in ALIVE: hit wins
    pulse(1'b1, 1'b1, 1'b0);
    status("hitadd", 2, 1'b1, 1'b0);
    // addLife in INVULN: lives recover, still invulnerable
    pulse(1'b0, 1'b1, 1'b0);
    status("invadd", 3, 1'b1, 1'b0);
    // hit+addLife in INVULN: addLife processed, hit ignored (saturated at 3)
    pulse(1'b1, 1'b1, 1'b0);
    status("invhitadd", 3, 1'b1, 1'b0);

    // Reset in the middle of a hidden blink phase
    pixelX = 11'd20;
    pixelY = 11'd10;
    for (int unsigned k = 1; k <= 65; k++) frame();
    check("mid.hidden", 32'(InsideRectangle), 32'd0);
    check("mid.invuln", 32'(invulnerable), 32'd1);
    resetN = 1'b1;
    tick();
    status("midrst", 3, 1'b0, 1'b0);
    check("midrst.inside", 32'(InsideRectangle), 32'd0);
    resetN = 1'b0;
    pix("midrst.pix", 20, 10, 1'b1, 4, 2);

    // hit on the same cycle as a frame pulse: that pulse does not count
    pulse(1'b1, 1'b0, 1'b1);
    status("hitsof", 2, 1'b1, 1'b0);
    for (int unsigned k = 1; k <= 119; k++) frame();
    check("hitsof.k119", 32'(invulnerable), 32'd1);
    frame();
    check("hitsof.k120", 32'(invulnerable), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
